// File: rtl/dff_ctrl_pkg.sv
// Shared constants for the DFF write arbiter: FSM encoding and width helpers.
package dff_ctrl_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  function automatic int owner_w(input int nreq);
    return (nreq < 2) ? 1 : $clog2(nreq);
  endfunction

  // A zero-length hold still needs a 1-bit counter so the RTL elaborates.
  function automatic int hold_w(input int hold_cycles);
    return (hold_cycles < 1) ? 1 : $clog2(hold_cycles + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: first set request at index >= ptr, wrapping to 0.
module rr_pick #(
  parameter int NREQ    = 4,
  parameter int OWNER_W = 2
) (
  input  logic [NREQ-1:0]    req,
  input  logic [OWNER_W-1:0] ptr,
  output logic               found,
  output logic [OWNER_W-1:0] winner
);

  logic [OWNER_W:0]   sum;
  logic [OWNER_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest hit is the last one written.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    idx    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (OWNER_W + 1)'(i);
      if (sum >= (OWNER_W + 1)'(NREQ)) begin
        sum = sum - (OWNER_W + 1)'(NREQ);
      end
      idx = sum[OWNER_W-1:0];
      if (req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/dff_write_arbiter.sv
// Round-robin controller granting one requester at a time write access to a shared register.
module dff_write_arbiter
  import dff_ctrl_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [NREQ-1:0]            Req,
  input  logic [NREQ*WIDTH-1:0]      D_in,
  output logic [NREQ-1:0]            Grant,
  output logic                       Ack,
  output logic [WIDTH-1:0]           Q,
  output logic                       Q_valid,
  output logic [owner_w(NREQ)-1:0]   Owner
);

  localparam int OWNER_W = owner_w(NREQ);
  localparam int HOLD_W  = hold_w(HOLD_CYCLES);

  logic [1:0]         state;
  logic [OWNER_W-1:0] ptr;
  logic [OWNER_W-1:0] win_idx;
  logic [OWNER_W-1:0] pick_idx;
  logic               pick_found;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [WIDTH-1:0]   slice;

  rr_pick #(
    .NREQ    (NREQ),
    .OWNER_W (OWNER_W)
  ) u_pick (
    .req    (Req),
    .ptr    (ptr),
    .found  (pick_found),
    .winner (pick_idx)
  );

  assign slice = D_in[int'(win_idx)*WIDTH +: WIDTH];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      ptr      <= '0;
      win_idx  <= '0;
      hold_cnt <= '0;
      Grant    <= '0;
      Ack      <= 1'b0;
      Q        <= '0;
      Q_valid  <= 1'b0;
      Owner    <= '0;
    end else begin
      Ack <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            Grant   <= NREQ'(1) << pick_idx;
            win_idx <= pick_idx;
            state   <= GRANT;
          end
        end
        GRANT: begin
          Grant <= '0;
          // A request withdrawn during the grant cycle is an abort: nothing is captured.
          if (Req[win_idx]) begin
            Q       <= slice;
            Owner   <= win_idx;
            Q_valid <= 1'b1;
            Ack     <= 1'b1;
            ptr     <= (win_idx == OWNER_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
            if (HOLD_CYCLES == 0) begin
              state <= IDLE;
            end else begin
              hold_cnt <= '0;
              state    <= HOLD;
            end
          end else begin
            state <= IDLE;
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
            hold_cnt <= '0;
            state    <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dff_write_arbiter.sv
// Directed and randomized bench for dff_write_arbiter against an abstract transaction model.
module tb_dff_write_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int HOLD  = 2;

  logic                  Clk = 1'b0;
  logic                  Reset;
  logic [NREQ-1:0]       Req;
  logic [NREQ*WIDTH-1:0] D_in;
  logic [NREQ-1:0]       Grant;
  logic                  Ack;
  logic [WIDTH-1:0]      Q;
  logic                  Q_valid;
  logic [1:0]            Owner;

  dff_write_arbiter #(
    .NREQ        (NREQ),
    .WIDTH       (WIDTH),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Req     (Req),
    .D_in    (D_in),
    .Grant   (Grant),
    .Ack     (Ack),
    .Q       (Q),
    .Q_valid (Q_valid),
    .Owner   (Owner)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Abstract model: "ready" looks for work, "offered" awaits the capture decision,
  // "cooling" counts down the quiet period after a capture.
  int              m_mode;
  int              m_cool;
  int              m_next;
  int              m_win;
  logic [NREQ-1:0] m_grant;
  logic            m_ack;
  logic [WIDTH-1:0] m_q;
  logic            m_qv;
  int              m_owner;

  task automatic model_reset();
    m_mode = 0; m_cool = 0; m_next = 0; m_win = 0;
    m_grant = '0; m_ack = 1'b0; m_q = '0; m_qv = 1'b0; m_owner = 0;
  endtask

  task automatic model_edge();
    m_ack = 1'b0;
    if (m_mode == 0) begin
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_next + k) % NREQ;
        if (Req[j]) begin
          m_win   = j;
          m_grant = '0;
          m_grant[j] = 1'b1;
          m_mode  = 1;
          break;
        end
      end
    end else if (m_mode == 1) begin
      m_grant = '0;
      if (Req[m_win]) begin
        m_q     = D_in[m_win*WIDTH +: WIDTH];
        m_qv    = 1'b1;
        m_owner = m_win;
        m_ack   = 1'b1;
        m_next  = (m_win + 1) % NREQ;
        m_cool  = HOLD;
        m_mode  = (HOLD > 0) ? 2 : 0;
      end else begin
        m_mode = 0;
      end
    end else begin
      m_cool = m_cool - 1;
      if (m_cool == 0) m_mode = 0;
    end
  endtask

  // One clock: model advances on the rising edge, outputs compared on the falling edge,
  // then the requester that was just acked withdraws its request.
  task automatic step();
    @(posedge Clk);
    if (Reset) model_reset();
    else model_edge();
    @(negedge Clk);
    check("grant", 32'(Grant), 32'(m_grant));
    check("ack", 32'(Ack), 32'(m_ack));
    check("q", 32'(Q), 32'(m_q));
    check("q_valid", 32'(Q_valid), 32'(m_qv));
    check("owner", 32'(Owner), 32'(m_owner));
    check("grant_onehot0", 32'($onehot0(Grant)), 32'd1);
    if (m_ack) Req[m_owner] = 1'b0;
  endtask

  task automatic wait_grant(output logic [NREQ-1:0] g, output int n);
    g = '0;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      n++;
      if (Grant != '0) begin
        g = Grant;
        break;
      end
    end
  endtask

  logic [NREQ-1:0] g;
  int              n;
  logic [NREQ-1:0] order[$];
  int              acks;

  initial begin
    Reset = 1'b1;
    Req   = '0;
    D_in  = '0;
    model_reset();
    step();
    step();
    check("reset_grant", 32'(Grant), 32'd0);
    check("reset_q_valid", 32'(Q_valid), 32'd0);
    Reset = 1'b0;

    // Single requester
    D_in[7:0] = 8'hA5;
    Req = 4'b0001;
    step();
    check("t1_grant", 32'(Grant), 32'h1);
    step();
    check("t1_q", 32'(Q), 32'hA5);
    check("t1_ack", 32'(Ack), 32'd1);
    check("t1_owner", 32'(Owner), 32'd0);
    check("t1_q_valid", 32'(Q_valid), 32'd1);
    step();
    check("t1_hold0", 32'(Grant), 32'd0);
    step();
    check("t1_hold1", 32'(Grant), 32'd0);

    // Capture by 2, then 3 and 0 requesting while it holds: search must wrap
    D_in = 32'h44_33_22_11;
    Req = 4'b0100;
    wait_grant(g, n);
    check("t3_pre_grant", 32'(g), 32'h4);
    step();
    Req = 4'b1001;
    wait_grant(g, n);
    check("t3_first", 32'(g), 32'h8);
    check("t3_masked_cycles", 32'(n), 32'd3);
    step();
    wait_grant(g, n);
    check("t3_second", 32'(g), 32'h1);
    step();

    // Request raised during HOLD is ignored until IDLE
    Req = 4'b0100;
    wait_grant(g, n);
    check("t5_grant", 32'(g), 32'h4);
    check("t5_wait", 32'(n), 32'd3);
    step();

    // Abort: drop the request while granted
    Req = 4'b0010;
    wait_grant(g, n);
    check("t4_grant", 32'(g), 32'h2);
    Req = 4'b0000;
    step();
    check("t4_no_ack", 32'(Ack), 32'd0);
    check("t4_owner_kept", 32'(Owner), 32'd2);
    check("t4_q_kept", 32'(Q), 32'h33);
    Req = 4'b0010;
    wait_grant(g, n);
    check("t4_regrant", 32'(g), 32'h2);

    // Asynchronous reset while Grant is up
    #2 Reset = 1'b1;
    #1;
    check("t6_grant", 32'(Grant), 32'd0);
    check("t6_ack", 32'(Ack), 32'd0);
    check("t6_q", 32'(Q), 32'd0);
    check("t6_q_valid", 32'(Q_valid), 32'd0);
    check("t6_owner", 32'(Owner), 32'd0);
    model_reset();
    step();
    step();
    Reset = 1'b0;

    // Contention from all four after reset
    Req = 4'b1111;
    acks = 0;
    order.delete();
    for (int c = 0; c < 40 && acks < 4; c++) begin
      step();
      if (Grant != '0) order.push_back(Grant);
      if (Ack) acks++;
    end
    check("t2_ack_count", 32'(acks), 32'd4);
    check("t2_grant_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4 && i < order.size(); i++) begin
      logic [NREQ-1:0] exp_g;
      exp_g = '0;
      exp_g[i] = 1'b1;
      check("t2_order", 32'(order[i]), 32'(exp_g));
    end

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      D_in = $urandom;
      for (int i = 0; i < NREQ; i++) begin
        if (!Req[i] && $urandom_range(3) == 0) Req[i] = 1'b1;
        else if (Req[i] && $urandom_range(15) == 0) Req[i] = 1'b0;
      end
      if ($urandom_range(199) == 0) begin
        Reset = 1'b1;
        step();
        Reset = 1'b0;
      end else begin
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
